// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: state encoding, default width, counter sizing.
// Add/subtract select is compiled in with SERIAL_SUB_ADD_MODE_EN.
package serial_subtractor_pkg;

    localparam int unsigned NB_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..nb inclusive: ceil(log2(nb+1)).
    function automatic int unsigned cnt_width(input int unsigned nb);
        return $clog2(nb + 1);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(NB_BITS_DEFAULT);

endpackage

// File: rtl/serial_subtractor_cell.sv
// Single-bit full subtractor cell (a - b - bin). With SERIAL_SUB_ADD_MODE_EN defined,
// op=1 turns it into a full adder (bin/bout act as carry-in/carry-out).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic op,
`endif
    output logic d,
    output logic bout
);

    logic borrow;

    assign d      = a ^ b ^ bin;
    assign borrow = (~a & b) | (~(a ^ b) & bin);

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic carry;

    assign carry = (a & b) | ((a ^ b) & bin);
    assign bout  = op ? carry : borrow;
`else
    assign bout  = borrow;
`endif

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bi, LSB first, one full_subtractor cell behind start/done.
// Optional SERIAL_SUB_ADD_MODE_EN adds an op input selecting addition (op=1).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned NB_BITS = NB_BITS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NB_BITS-1:0] a,
    input  logic [NB_BITS-1:0] b,
    input  logic               bi,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic               op,
`endif
    output logic               busy,
    output logic               done,
    output logic [NB_BITS-1:0] d,
    output logic               bo
);

    localparam int unsigned CNT_W = cnt_width(NB_BITS);

    state_t             state, state_next;
    logic [NB_BITS-1:0] a_sr, a_sr_nxt;
    logic [NB_BITS-1:0] b_sr, b_sr_nxt;
    logic [NB_BITS-2:0] res_sr, res_nxt;
    logic               br, br_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               busy_nxt, done_nxt, bo_nxt;
    logic [NB_BITS-1:0] d_nxt;
    logic               cell_d, cell_bo;
    logic               last_bit;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic op_q, op_nxt;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op   (op_q),
`endif
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign last_bit = (cnt == CNT_W'(NB_BITS - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bo     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_q   <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            a_sr   <= a_sr_nxt;
            b_sr   <= b_sr_nxt;
            res_sr <= res_nxt;
            br     <= br_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            d      <= d_nxt;
            bo     <= bo_nxt;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_q   <= op_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values; busy spans capture through the done pulse
    always_comb begin
        a_sr_nxt = a_sr;
        b_sr_nxt = b_sr;
        res_nxt  = res_sr;
        br_nxt   = br;
        cnt_nxt  = cnt;
        d_nxt    = d;
        bo_nxt   = bo;
        busy_nxt = (state_next != IDLE) || (state == DONE);
        done_nxt = (state == DONE);
`ifdef SERIAL_SUB_ADD_MODE_EN
        op_nxt   = op_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    a_sr_nxt = a;
                    b_sr_nxt = b;
                    br_nxt   = bi;
                    res_nxt  = '0;
                    cnt_nxt  = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    op_nxt   = op;
`endif
                end
            end
            SHIFT: begin
                a_sr_nxt = a_sr >> 1;
                b_sr_nxt = b_sr >> 1;
                res_nxt  = (NB_BITS-1)'({cell_d, res_sr} >> 1);
                br_nxt   = cell_bo;
                cnt_nxt  = cnt + CNT_W'(1);
                if (last_bit) begin
                    d_nxt  = {cell_d, res_sr};
                    bo_nxt = cell_bo;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed bench for serial_subtractor, checked against an arithmetic model.
// Define SERIAL_SUB_ADD_MODE_EN to also exercise the op=1 addition path.
module tb_serial_subtractor;

    localparam int NB  = 4;
    localparam int MOD = 1 << NB;
    localparam int LAT = NB + 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NB-1:0] a     = '0;
    logic [NB-1:0] b     = '0;
    logic          bi    = 1'b0;
    logic          op    = 1'b0;
    logic          busy, done, bo;
    logic [NB-1:0] d;

    int vectors     = 0;
    int miscompares = 0;

    serial_subtractor #(.NB_BITS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op    (op),
`endif
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Arithmetic contract: subtraction wraps mod 2^NB with borrow on underflow; addition carries out.
    function automatic void ref_op(input int ua, input int ub, input int ubi, input int uop,
                                   output int rd, output int rbo);
        int r;
        r   = uop != 0 ? ua + ub + ubi : ua - ub - ubi;
        rd  = ((r % MOD) + MOD) % MOD;
        rbo = uop != 0 ? int'(r >= MOD) : int'(r < 0);
    endfunction

    // Model: cycles elapsed since an accepted start (-1 when idle)
    int m_cnt   = -1;
    bit m_valid = 1'b0;
    int pend_d  = 0, pend_bo = 0, exp_d = 0, exp_bo = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt   = -1;
            exp_d   = 0;
            exp_bo  = 0;
            m_valid = 1'b1;
        end else if ((m_cnt < 0 || m_cnt == LAT - 1) && start) begin
            ref_op(int'(a), int'(b), int'(bi), int'(op), pend_d, pend_bo);
            m_cnt = 0;
        end else if (m_cnt >= 0) begin
            m_cnt++;
            if (m_cnt == NB) begin
                exp_d  = pend_d;
                exp_bo = pend_bo;
            end
            if (m_cnt >= LAT) m_cnt = -1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, m_cnt >= 0);
            chk("done", done, m_cnt == LAT - 1);
            chk("d", d, exp_d);
            chk("bo", bo, exp_bo);
        end
    end

    task automatic start_op(input int ua, input int ub, input int ubi, input int uop);
        @(posedge clk);
        #1;
        a     = NB'(ua);
        b     = NB'(ub);
        bi    = 1'(ubi);
        op    = 1'(uop);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = NB'($urandom);
        b     = NB'($urandom);
        bi    = 1'($urandom);
    endtask

    task automatic wait_done(input string nm, input int lat, input int ed, input int ebo);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                chk({nm, "_lat"}, i, lat);
                chk({nm, "_d"}, d, ed);
                chk({nm, "_bo"}, bo, ebo);
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
    endtask

    task automatic count_done(input string nm, input int ncyc, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk(nm, n, exp_n);
    endtask

    initial begin
        int rd, rbo;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d", d, 0);
        chk("rst_bo", bo, 0);

        start_op(5, 3, 0, 0);   wait_done("5-3", LAT, 2, 0);
        start_op(3, 5, 0, 0);   wait_done("3-5", LAT, 14, 1);
        start_op(0, 0, 1, 0);   wait_done("0-0-1", LAT, 15, 1);
        start_op(15, 15, 1, 0); wait_done("15-15-1", LAT, 15, 1);

        for (int ia = 0; ia < MOD; ia++)
            for (int ib = 0; ib < MOD; ib++)
                for (int ibi = 0; ibi < 2; ibi++) begin
                    ref_op(ia, ib, ibi, 0, rd, rbo);
                    start_op(ia, ib, ibi, 0);
                    wait_done("exh", LAT, rd, rbo);
                end

        // Restart attempt during SHIFT must be ignored
        start_op(7, 2, 0, 0);
        @(posedge clk);
        #1;
        a = 4'd9; b = 4'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                chk("repulse_d", d, 5);
                chk("repulse_bo", bo, 0);
            end
        end
        start_op(7, 2, 0, 0); wait_done("7-2", LAT, 5, 0);

        // Reset in the second SHIFT cycle aborts silently
        start_op(5, 3, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_d", d, 0);
        chk("abort_bo", bo, 0);
        count_done("abort_ndone", 10, 0);
        start_op(12, 5, 1, 0); wait_done("12-5-1", LAT, 6, 0);

`ifdef SERIAL_SUB_ADD_MODE_EN
        start_op(9, 8, 1, 1); wait_done("add_9+8+1", LAT, 2, 1);
        start_op(9, 8, 1, 0); wait_done("sub_9-8-1", LAT, 0, 0);
`endif

        // Random traffic with occasional resets; the compare process checks every cycle
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            a     = NB'($urandom);
            b     = NB'($urandom);
            bi    = 1'($urandom);
`ifdef SERIAL_SUB_ADD_MODE_EN
            op    = 1'($urandom);
`endif
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes d = a - b - bi one bit per clock, LSB first, through a single full-subtractor cell.
- Subtraction counterpart to the team's ripple-carry adder. Replaces NB_BITS combinational cells with one cell plus a shift datapath.
- Sits in the arithmetic library behind a start/done handshake. Used where area matters more than latency.

Parameters:
NB_BITS, 4, operand and result width in bits (legal range 2..32)

Ports:
clk     input   1        rising-edge clock
rst_n   input   1        synchronous reset, active-low
start   input   1        request; sampled only in IDLE
a       input   NB_BITS  minuend, captured on accepted start
b       input   NB_BITS  subtrahend, captured on accepted start
bi      input   1        borrow-in, captured on accepted start
busy    output  1        high while a subtraction is in progress (SHIFT or DONE)
done    output  1        one-cycle pulse: d/bo valid
d       output  NB_BITS  difference, registered
bo      output  1        borrow-out, registered

Behaviour:
- One clock domain. Reset is synchronous and active-low: on a clk edge with rst_n=0, state=IDLE, busy=0, done=0, d=0, bo=0, bit counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 latches a, b and bi into shift registers, clears the counter, then goes to SHIFT. With start=0 the state holds.
- SHIFT: each cycle processes bit 0 of the operand registers through the cell:
  - diff = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - diff shifts into the result register from the MSB side; both operand registers shift right; the counter increments.
- SHIFT runs exactly NB_BITS cycles, then goes to DONE. At that edge, d is loaded from the result register and bo from the final borrow.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: start sampled at edge k gives done high in the cycle after edge k+NB_BITS+1. Throughput is one operation per NB_BITS+2 cycles.
- Arithmetic contract:
  - {bo,d} satisfies a - b - bi = d - bo*2^NB_BITS.
  - d = (a - b - bi) mod 2^NB_BITS.
  - bo = 1 iff a < b + bi.
- d and bo hold their values until the next DONE or reset. They do not change during a following SHIFT phase.
- start while busy is ignored: no re-capture, no restart. start held high through DONE begins a new operation on the first IDLE cycle.
- Reset mid-operation aborts immediately. No done pulse is emitted; outputs take reset values.
- Inputs a, b and bi may change freely after capture.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- Defined:
  - Extra input port op (1 bit), captured with the operands.
  - op=0 is subtraction as above.
  - op=1 is addition: cell computes diff = a0 ^ b0 ^ br and carry = majority(a0, b0, br); bi acts as carry-in and bo as carry-out, so {bo,d} = a + b + bi.
- Undefined: no op port; the block is subtract-only.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default width constant NB_BITS_DEFAULT=4;
  - a counter-width constant computed as ceil(log2(NB_BITS+1)).
- One sub-module: full_subtractor (a, b, bin -> d, bout), purely combinational. Under SERIAL_SUB_ADD_MODE_EN it also takes the op select.
- FSM and shift registers stay in serial_subtractor.

Test Plan:
- a=5, b=3, bi=0, pulse start → done exactly 6 cycles after the start edge; d=2, bo=0; busy high for 6 cycles.
- a=3, b=5, bi=0 → d=14, bo=1. Also a=0, b=0, bi=1 → d=15, bo=1. Also a=15, b=15, bi=1 → d=15, bo=1.
- Exhaustive: all 16x16x2 operand combinations, one start per operation → 512 cases, 0 failures against the arithmetic contract.
- start re-pulsed with a=9, b=1 during SHIFT of a 7-2 operation → ignored; done fires once with d=5, bo=0.
- rst_n=0 for one cycle during the second SHIFT cycle → no done pulse; busy=0, d=0, bo=0. A new start completes normally.
- With SERIAL_SUB_ADD_MODE_EN defined, op=1, a=9, b=8, bi=1 → d=2, bo=1. With op=0, the same operands give d=0, bo=0.
